// File: rtl/instr_fetch_unit.sv
// Instruction-fetch front end: owns the PC, issues one outstanding word read at a time,
// and buffers returned instructions with their PC in a small FIFO toward decode.
//
// state   | meaning
// --------+----------------------------------------------------------
// S_FETCH | request for pc offered while the buffer has room
// S_WAIT  | one request accepted, waiting for its in-order response
module instr_fetch_unit #(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_PC  = '0,
    parameter int              BUF_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,
    output logic            if_valid,
    input  logic            if_ready,
    output logic [XLEN-1:0] if_pc,
    output logic [31:0]     if_instr,
    output logic            misalign
);
    localparam int             PTR_W   = $clog2(BUF_DEPTH);
    localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(BUF_DEPTH);

    typedef enum logic {S_FETCH, S_WAIT} state_t;

    state_t           state_q, state_d;
    logic [XLEN-1:0]  pc_q, pc_d;
    logic [XLEN-1:0]  req_pc_q, req_pc_d;
    logic             kill_q, kill_d;
    logic             misalign_q, misalign_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic [XLEN-1:0]  buf_pc_q    [BUF_DEPTH];
    logic [XLEN-1:0]  buf_pc_d    [BUF_DEPTH];
    logic [31:0]      buf_instr_q [BUF_DEPTH];
    logic [31:0]      buf_instr_d [BUF_DEPTH];
    logic             req_fire;
    logic             push;
    logic             pop;

    assign imem_req_addr = pc_q;
    assign if_valid      = (count_q != '0);
    assign if_pc         = buf_pc_q[rd_ptr_q];
    assign if_instr      = buf_instr_q[rd_ptr_q];
    assign misalign      = misalign_q;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        req_pc_d    = req_pc_q;
        kill_d      = kill_q;
        misalign_d  = 1'b0;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        count_d     = count_q;
        buf_pc_d    = buf_pc_q;
        buf_instr_d = buf_instr_q;
        push        = 1'b0;

        // Issue only while a slot is free, so a push can never hit a full buffer.
        imem_req_valid = (state_q == S_FETCH) && (count_q < DEPTH_C);
        req_fire       = imem_req_valid && imem_req_ready;
        pop            = if_valid && if_ready;

        case (state_q)
            S_FETCH: begin
                if (req_fire) begin
                    req_pc_d = pc_q;
                    pc_d     = pc_q + XLEN'(4);
                    state_d  = S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem_rsp_valid) begin
                    push    = !kill_q;
                    kill_d  = 1'b0;
                    state_d = S_FETCH;
                end
            end
            default: state_d = S_FETCH;
        endcase

        if (redirect_valid) begin
            pc_d       = {redirect_pc[XLEN-1:2], 2'b00};
            misalign_d = |redirect_pc[1:0];
            push       = 1'b0;
            // Mark the response still owed by memory as dead; one landing this cycle is simply dropped.
            if ((state_q == S_FETCH) ? req_fire : !imem_rsp_valid)
                kill_d = 1'b1;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
        end else begin
            if (push) begin
                buf_pc_d[wr_ptr_q]    = req_pc_q;
                buf_instr_d[wr_ptr_q] = imem_rsp_data;
                wr_ptr_d              = wr_ptr_q + PTR_W'(1);
            end
            if (pop)
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            count_d = count_q + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_FETCH;
            pc_q        <= RESET_PC;
            req_pc_q    <= '0;
            kill_q      <= 1'b0;
            misalign_q  <= 1'b0;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            buf_pc_q    <= '{default: '0};
            buf_instr_q <= '{default: '0};
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            req_pc_q    <= req_pc_d;
            kill_q      <= kill_d;
            misalign_q  <= misalign_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            buf_pc_q    <= buf_pc_d;
            buf_instr_q <= buf_instr_d;
        end
    end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: behavioural instruction memory plus a scoreboard of
// expected {pc, instr} entries, flushed on redirect/reset and popped on decode handshakes.
module tb_instr_fetch_unit;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic        misalign;

    always #5 clk = ~clk;

    instr_fetch_unit #(.XLEN(32), .RESET_PC(RESET_PC), .BUF_DEPTH(2)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_pc          (if_pc),
        .if_instr       (if_instr),
        .misalign       (misalign)
    );

    typedef struct {
        logic [31:0] addr;
        int          due;
        bit          dead;
    } pend_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    pend_t       pend_q[$];
    exp_t        exp_q[$];
    int          n_cmp = 0;
    int          n_err = 0;
    int          cnum = 0;
    int          lat = 1;
    int          fire_cnt = 0;
    int          pop_cnt = 0;
    logic [31:0] exp_pc = RESET_PC;
    logic        exp_mis = 1'b0;
    logic [31:0] last_fire_addr = '1;
    bit          armed = 0;
    bit          got = 0;
    logic [31:0] first_pop = '0;

    function automatic logic [31:0] instr_of(logic [31:0] a);
        return a ^ 32'hC0DE_0013;
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // One clock: memory drives its response, handshakes are modelled, then the edge.
    task automatic cyc();
        logic  fire;
        logic  pop;
        pend_t e;
        exp_t  x;
        if (pend_q.size() > 0 && pend_q[0].due <= cnum) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = instr_of(pend_q[0].addr);
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = '0;
        end
        #1;
        fire = imem_req_valid && imem_req_ready;
        pop  = if_valid && if_ready;
        if (!rst_n) begin
            if (imem_rsp_valid) void'(pend_q.pop_front());
            foreach (pend_q[i]) pend_q[i].dead = 1;
            exp_q.delete();
            exp_pc  = RESET_PC;
            exp_mis = 1'b0;
        end else begin
            exp_mis = 1'b0;
            if (pop) begin
                pop_cnt++;
                if (armed && !got) begin
                    got       = 1;
                    first_pop = if_pc;
                end
                if (exp_q.size() == 0) begin
                    chk("unexpected_pop", 32'(if_valid), 32'(0));
                end else begin
                    x = exp_q.pop_front();
                    chk("if_pc", if_pc, x.pc);
                    chk("if_instr", if_instr, x.instr);
                end
            end
            if (imem_rsp_valid) begin
                e = pend_q.pop_front();
                if (!e.dead && !redirect_valid) exp_q.push_back('{pc: e.addr, instr: instr_of(e.addr)});
            end
            if (fire) begin
                fire_cnt++;
                last_fire_addr = imem_req_addr;
                chk("req_addr", imem_req_addr, exp_pc);
                pend_q.push_back('{addr: exp_pc, due: cnum + lat, dead: redirect_valid});
                exp_pc = exp_pc + 32'd4;
            end
            if (redirect_valid) begin
                exp_q.delete();
                foreach (pend_q[i]) pend_q[i].dead = 1;
                exp_pc  = {redirect_pc[31:2], 2'b00};
                exp_mis = |redirect_pc[1:0];
            end
        end
        @(posedge clk);
        cnum++;
        @(negedge clk);
        chk("if_valid", 32'(if_valid), 32'(exp_q.size() != 0));
        chk("misalign", 32'(misalign), 32'(exp_mis));
    endtask

    task automatic do_reset();
        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        cyc();
        cyc();
        rst_n    = 1'b1;
        fire_cnt = 0;
        pop_cnt  = 0;
    endtask

    task automatic redirect_to(logic [31:0] tgt);
        redirect_valid = 1'b1;
        redirect_pc    = tgt;
        cyc();
        redirect_valid = 1'b0;
    endtask

    task automatic expect_next_pop(string tag, logic [31:0] pc);
        armed = 1;
        got   = 0;
        for (int i = 0; i < 40 && !got; i++) cyc();
        chk({tag, "_seen"}, 32'(got), 32'(1));
        if (got) chk(tag, first_pop, pc);
        armed = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        imem_req_ready = 1'b1;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        if_ready       = 1'b1;

        // Reset state
        do_reset();
        chk("rst_addr", imem_req_addr, RESET_PC);
        chk("rst_if_valid", 32'(if_valid), 32'(0));
        chk("rst_misalign", 32'(misalign), 32'(0));

        // Sequential streaming, 1-cycle memory
        for (int i = 0; i < 12; i++) cyc();
        chk("seq_fires", 32'(fire_cnt), 32'(6));
        chk("seq_pops", 32'(pop_cnt), 32'(5));

        // Decode backpressure fills the 2-entry buffer
        if_ready = 1'b0;
        do_reset();
        for (int i = 0; i < 10; i++) cyc();
        chk("bp_fires", 32'(fire_cnt), 32'(2));
        chk("bp_req_valid", 32'(imem_req_valid), 32'(0));
        chk("bp_head_pc", if_pc, 32'h0);
        chk("bp_head_instr", if_instr, instr_of(32'h0));
        fire_cnt = 0;
        if_ready = 1'b1;
        cyc();
        if_ready = 1'b0;
        for (int i = 0; i < 4; i++) cyc();
        chk("bp_refill_fires", 32'(fire_cnt), 32'(1));
        chk("bp_refill_addr", last_fire_addr, 32'h8);
        chk("bp_head_after_pop", if_pc, 32'h4);

        // Redirect while the 0x8 request is outstanding
        if_ready = 1'b1;
        lat      = 3;
        do_reset();
        for (int i = 0; i < 30 && last_fire_addr != 32'h8; i++) cyc();
        chk("redir_reached", last_fire_addr, 32'h8);
        redirect_to(32'h100);
        chk("redir_if_valid", 32'(if_valid), 32'(0));
        expect_next_pop("redir_first_pc", 32'h100);

        // Misaligned redirect
        redirect_to(32'h202);
        chk("mis_pulse", 32'(misalign), 32'(1));
        cyc();
        chk("mis_clear", 32'(misalign), 32'(0));
        expect_next_pop("mis_resume_pc", 32'h200);

        // Redirect coinciding with a request handshake and a decode pop
        lat = 1;
        for (int i = 0; i < 20 && !(imem_req_valid && if_valid); i++) cyc();
        chk("coinc_reached", 32'(imem_req_valid && if_valid), 32'(1));
        redirect_to(32'h300);
        chk("coinc_if_valid", 32'(if_valid), 32'(0));
        expect_next_pop("coinc_first_pc", 32'h300);

        // PC wrap at the top of the address space
        redirect_to(32'hFFFF_FFFC);
        expect_next_pop("wrap_top_pc", 32'hFFFF_FFFC);
        expect_next_pop("wrap_zero_pc", 32'h0);

        // Reset while waiting; the stale response lands right after reset
        lat = 2;
        for (int i = 0; i < 20 && !(pend_q.size() > 0 && pend_q[0].due > cnum && !imem_req_valid); i++) cyc();
        chk("rstw_reached", 32'(!imem_req_valid && pend_q.size() > 0), 32'(1));
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        chk("rstw_addr", imem_req_addr, RESET_PC);
        chk("rstw_if_valid", 32'(if_valid), 32'(0));
        expect_next_pop("rstw_first_pc", RESET_PC);
        for (int i = 0; i < 6; i++) cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
